// File: rtl/game_pkg.sv
// Shared game definitions: state encodings, screen/sprite geometry, and the
// lane-engine FSM states.
package game_pkg;

  typedef enum logic [1:0] {
    START   = 2'b00,
    PLAYING = 2'b01,
    OVER    = 2'b10
  } game_state_t;

  localparam int SCREEN_W        = 640;
  localparam int OBSTACLE_WIDTH  = 32;
  localparam int OBSTACLE_HEIGHT = 32;
  localparam int PLAYER_WIDTH    = 16;
  localparam int PLAYER_HEIGHT   = 16;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } lane_fsm_t;

endpackage

// File: rtl/obstacle_lane_engine_lfsr16.sv
// 16-bit Galois LFSR (mask 16'hB400, right shift) that advances only while enabled.
module lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= seed;
    else if (en)
      q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
  end

endmodule

// File: rtl/obstacle_lane_engine.sv
// Obstacle lane engine: loads a random phase per row, then scrolls every row
// once per PLAYING frame tick with a level-dependent speed.
//
// state | meaning
// LOAD  | one row per cycle gets phase from LFSR, loading=1, ticks ignored
// RUN   | rows scroll on PLAYING frame ticks; entry to START reloads
module obstacle_lane_engine
  import game_pkg::*;
#(
  parameter int          NUM_ROWS          = 6,
  parameter int          OBSTACLES_PER_ROW = 10,
  parameter int          SPACING           = 96,
  parameter int          ROW_Y0            = 80,
  parameter int          ROW_PITCH         = 48,
  parameter int          LEVEL_FRAMES      = 600,
  parameter int          MAX_SPEED         = 6,
  parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [1:0] state,
  output logic [9:0] obstacle_x [NUM_ROWS][OBSTACLES_PER_ROW],
  output logic [8:0] obstacle_y [NUM_ROWS][OBSTACLES_PER_ROW],
  output logic [2:0] level,
  output logic       loading
);

  localparam int PW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int CW = $clog2(LEVEL_FRAMES + 1);

  lane_fsm_t   fsm, fsm_next;
  logic [PW-1:0] ptr;
  logic [1:0]  prev_state;
  logic [CW-1:0] frame_cnt;
  logic [15:0] lfsr_q;
  logic        lfsr_en;
  logic        reload;
  logic        move;
  logic        load_last;
  logic        unused_lfsr_hi;

  function automatic logic [9:0] row_speed(input int r, input logic [2:0] lvl);
    int s;
    s = 1 + (r % 3) + int'(lvl);
    if (s > MAX_SPEED) s = MAX_SPEED;
    return 10'(s);
  endfunction

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (lfsr_en),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  assign unused_lfsr_hi = ^lfsr_q[15:10];

  // Reload fires on entry to START; a tick in the same cycle never moves rows.
  assign reload    = (fsm == RUN) && (state == START) && (prev_state != START);
  assign move      = (fsm == RUN) && frame_tick && (state == PLAYING) && !reload;
  assign load_last = (ptr == PW'(NUM_ROWS - 1));

  always_ff @(posedge clk) begin
    if (reset)
      fsm <= LOAD;
    else
      fsm <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      LOAD: if (load_last) fsm_next = RUN;
      RUN:  if (reload)    fsm_next = LOAD;
      default: fsm_next = LOAD;
    endcase
  end

  always_comb begin
    loading = (fsm == LOAD);
    lfsr_en = (fsm == LOAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr        <= '0;
      prev_state <= START;
      frame_cnt  <= '0;
      level      <= 3'd0;
      for (int r = 0; r < NUM_ROWS; r++)
        for (int c = 0; c < OBSTACLES_PER_ROW; c++)
          obstacle_x[r][c] <= 10'(c * SPACING);
    end else begin
      prev_state <= state;
      if (fsm == LOAD) begin
        for (int r = 0; r < NUM_ROWS; r++)
          for (int c = 0; c < OBSTACLES_PER_ROW; c++)
            if (ptr == PW'(r))
              obstacle_x[r][c] <= lfsr_q[9:0] + 10'(c * SPACING);
        ptr <= load_last ? '0 : ptr + 1'b1;
      end else if (reload) begin
        ptr       <= '0;
        level     <= 3'd0;
        frame_cnt <= '0;
      end else if (move) begin
        // Speed uses the level before this tick's possible increment.
        for (int r = 0; r < NUM_ROWS; r++)
          for (int c = 0; c < OBSTACLES_PER_ROW; c++)
            if (r % 2 == 0)
              obstacle_x[r][c] <= obstacle_x[r][c] + row_speed(r, level);
            else
              obstacle_x[r][c] <= obstacle_x[r][c] - row_speed(r, level);
        if (frame_cnt == CW'(LEVEL_FRAMES - 1)) begin
          frame_cnt <= '0;
          if (level != 3'd7) level <= level + 3'd1;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++)
      for (int c = 0; c < OBSTACLES_PER_ROW; c++)
        obstacle_y[r][c] = 9'(ROW_Y0 + r * ROW_PITCH);
  end

endmodule

// File: tb/tb_obstacle_lane_engine.sv
// Bench for obstacle_lane_engine: two instances (LEVEL_FRAMES=4 and 2000) share
// stimulus and are compared against an arithmetic reference model.
module tb_obstacle_lane_engine;
  import game_pkg::*;

  localparam int NR = 6;
  localparam int NC = 10;
  localparam int SP = 96;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [1:0] state = 2'b00;
  logic [9:0] xa [NR][NC];
  logic [9:0] xb [NR][NC];
  logic [8:0] ya [NR][NC];
  logic [8:0] yb [NR][NC];
  logic [2:0] lva, lvb;
  logic       lda, ldb;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  obstacle_lane_engine #(.LEVEL_FRAMES(4)) dut_a (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .state(state),
    .obstacle_x(xa), .obstacle_y(ya), .level(lva), .loading(lda));

  obstacle_lane_engine #(.LEVEL_FRAMES(2000)) dut_b (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .state(state),
    .obstacle_x(xb), .obstacle_y(yb), .level(lvb), .loading(ldb));

  // Reference model: index 0 mirrors dut_a, index 1 mirrors dut_b.
  int          mx [2][NR][NC];
  int          mlev [2];
  int          mcnt [2];
  int          mlf [2] = '{4, 2000};
  logic [15:0] mlfsr;
  bit          mloading;
  int          mptr;
  logic [1:0]  mprev;
  string       dmsg;
  int          first_ph [NR];

  function automatic logic [15:0] galois(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic model_step();
    bit rl;
    int spd;
    if (reset) begin
      mlfsr = 16'hACE1; mloading = 1; mptr = 0; mprev = 2'b00;
      for (int i = 0; i < 2; i++) begin
        mlev[i] = 0; mcnt[i] = 0;
        for (int r = 0; r < NR; r++)
          for (int c = 0; c < NC; c++) mx[i][r][c] = c * SP;
      end
    end else begin
      rl = !mloading && state == 2'b00 && mprev != 2'b00;
      if (mloading) begin
        for (int i = 0; i < 2; i++)
          for (int c = 0; c < NC; c++)
            mx[i][mptr][c] = (int'(mlfsr[9:0]) + c * SP) % 1024;
        mlfsr = galois(mlfsr);
        mptr++;
        if (mptr == NR) begin mloading = 0; mptr = 0; end
      end else if (rl) begin
        mloading = 1; mptr = 0;
        for (int i = 0; i < 2; i++) begin mlev[i] = 0; mcnt[i] = 0; end
      end else if (frame_tick && state == 2'b01) begin
        for (int i = 0; i < 2; i++) begin
          for (int r = 0; r < NR; r++) begin
            spd = 1 + r % 3 + mlev[i];
            if (spd > 6) spd = 6;
            for (int c = 0; c < NC; c++)
              mx[i][r][c] = (r % 2 == 0) ? (mx[i][r][c] + spd) % 1024
                                         : (mx[i][r][c] - spd + 1024) % 1024;
          end
          mcnt[i]++;
          if (mcnt[i] == mlf[i]) begin
            mcnt[i] = 0;
            if (mlev[i] < 7) mlev[i]++;
          end
        end
      end
      mprev = state;
    end
  endtask

  function automatic int model_diffs();
    int n = 0;
    logic [9:0] g;
    dmsg = "";
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < NR; r++)
        for (int c = 0; c < NC; c++) begin
          g = (i == 0) ? xa[r][c] : xb[r][c];
          if (g !== 10'(mx[i][r][c])) begin
            if (n == 0) dmsg = $sformatf("inst%0d x[%0d][%0d] got %0d want %0d", i, r, c, g, mx[i][r][c]);
            n++;
          end
        end
    if (lva !== 3'(mlev[0]) || lvb !== 3'(mlev[1])) begin
      if (n == 0) dmsg = $sformatf("level got %0d/%0d want %0d/%0d", lva, lvb, mlev[0], mlev[1]);
      n++;
    end
    if (lda !== mloading || ldb !== mloading) begin
      if (n == 0) dmsg = $sformatf("loading got %0b/%0b want %0b", lda, ldb, mloading);
      n++;
    end
    return n;
  endfunction

  task automatic cycle(input bit tk, input logic [1:0] st);
    @(negedge clk);
    frame_tick = tk;
    state = st;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic play_tick();
    cycle(1'b1, PLAYING);
    cycle(1'b0, PLAYING);
  endtask

  task automatic test_reset();
    int n;
    logic [15:0] lf;
    int want;
    reset = 1'b1;
    repeat (3) cycle(1'b0, START);
    tests++;
    if (lda !== 1'b1 || ldb !== 1'b1) begin failed++; $display("FAIL reset_loading got %b/%b want 1", lda, ldb); end
    tests++;
    if (lva !== 3'd0 || lvb !== 3'd0) begin failed++; $display("FAIL reset_level got %0d/%0d want 0", lva, lvb); end
    n = 0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) if (xa[r][c] !== 10'(c * SP)) n++;
    tests++;
    if (n !== 0) begin failed++; $display("FAIL reset_x %0d entries differ from c*96", n); end
    for (int c = 0; c < NC; c++) begin
      tests++;
      if (ya[3][c] !== 9'd224) begin failed++; $display("FAIL y_row3 c=%0d got %0d want 224", c, ya[3][c]); end
    end
    n = 0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) if (ya[r][c] !== 9'(80 + 48 * r) || yb[r][c] !== 9'(80 + 48 * r)) n++;
    tests++;
    if (n !== 0) begin failed++; $display("FAIL y_all %0d entries wrong", n); end

    reset = 1'b0;
    n = 0;
    do begin cycle(1'b0, START); n++; end while (lda === 1'b1 && n < 20);
    tests++;
    if (n !== 6) begin failed++; $display("FAIL load_len got %0d cycles want 6", n); end

    lf = 16'hACE1;
    n = 0;
    for (int r = 0; r < NR; r++) begin
      first_ph[r] = int'(lf[9:0]);
      for (int c = 0; c < NC; c++) begin
        want = (first_ph[r] + c * SP) % 1024;
        if (xa[r][c] !== 10'(want) || xb[r][c] !== 10'(want)) n++;
      end
      lf = galois(lf);
    end
    tests++;
    if (n !== 0) begin failed++; $display("FAIL first_phases %0d entries wrong", n); end
    n = 0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (((int'(xa[r][c]) - int'(xa[r][0])) & 1023) != c * SP) n++;
    tests++;
    if (n !== 0) begin failed++; $display("FAIL spacing %0d entries wrong", n); end
    tests++;
    if (model_diffs() !== 0) begin failed++; $display("FAIL model_reset %s", dmsg); end
  endtask

  task automatic test_start_ticks();
    logic [9:0] snap [NR][NC];
    int n = 0;
    snap = xa;
    repeat (10) begin cycle(1'b1, START); cycle(1'b0, START); end
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) if (xa[r][c] !== snap[r][c]) n++;
    tests++;
    if (n !== 0) begin failed++; $display("FAIL start_frozen %0d entries moved", n); end
    tests++;
    if (lva !== 3'd0) begin failed++; $display("FAIL start_level got %0d want 0", lva); end
    tests++;
    if (model_diffs() !== 0) begin failed++; $display("FAIL model_start %s", dmsg); end
  endtask

  task automatic test_single_tick();
    logic [9:0] snap [NR][NC];
    int d [NR] = '{1, -2, 3, -1, 2, -3};
    int n;
    snap = xb;
    play_tick();
    for (int r = 0; r < NR; r++) begin
      n = 0;
      for (int c = 0; c < NC; c++)
        if (xb[r][c] !== 10'((int'(snap[r][c]) + d[r] + 1024) & 1023)) n++;
      tests++;
      if (n !== 0) begin failed++; $display("FAIL tick_row%0d %0d entries, x[0] got %0d want %0d", r, n, xb[r][0], (int'(snap[r][0]) + d[r] + 1024) & 1023); end
    end
    tests++;
    if (model_diffs() !== 0) begin failed++; $display("FAIL model_tick %s", dmsg); end
  endtask

  task automatic test_levels();
    int tk = 1;
    int want;
    logic [9:0] s0;
    logic [9:0] snap [NR][NC];
    int n;
    while (tk < 40) begin
      play_tick();
      tk++;
      want = (tk / 4 > 7) ? 7 : tk / 4;
      tests++;
      if (lva !== 3'(want)) begin failed++; $display("FAIL level_tk%0d got %0d want %0d", tk, lva, want); end
      if (tk == 4 || tk == 20) begin
        s0 = xa[0][0];
        play_tick();
        tk++;
        tests++;
        if (((int'(xa[0][0]) - int'(s0)) & 1023) != ((tk == 5) ? 2 : 6)) begin
          failed++; $display("FAIL row0_speed_tk%0d got %0d want %0d", tk, (int'(xa[0][0]) - int'(s0)) & 1023, (tk == 5) ? 2 : 6);
        end
      end
    end
    tests++;
    if (lva !== 3'd7) begin failed++; $display("FAIL level_sat got %0d want 7", lva); end
    snap = xa;
    play_tick();
    n = 0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (xa[r][c] !== 10'((int'(snap[r][c]) + ((r % 2 == 0) ? 6 : -6) + 1024) & 1023)) n++;
    tests++;
    if (n !== 0) begin failed++; $display("FAIL max_speed %0d entries wrong", n); end
    tests++;
    if (lvb !== 3'd0) begin failed++; $display("FAIL level_b got %0d want 0", lvb); end
    tests++;
    if (model_diffs() !== 0) begin failed++; $display("FAIL model_levels %s", dmsg); end
  endtask

  task automatic test_wrap();
    logic [9:0] p0, p1;
    bit w0 = 0, w1 = 0;
    for (int k = 0; k < 1100; k++) begin
      p0 = xb[0][0];
      p1 = xb[1][0];
      play_tick();
      tests++;
      if (xb[0][0] !== 10'((int'(p0) + 1) & 1023)) begin
        failed++; $display("FAIL wrap_row0 k=%0d got %0d want %0d", k, xb[0][0], (int'(p0) + 1) & 1023);
      end
      tests++;
      if (xb[1][0] !== 10'((int'(p1) - 2) & 1023)) begin
        failed++; $display("FAIL wrap_row1 k=%0d got %0d want %0d", k, xb[1][0], (int'(p1) - 2) & 1023);
      end
      if (p0 == 10'd1023 && xb[0][0] == 10'd0) w0 = 1;
      if (xb[1][0] > p1) w1 = 1;
      if ((k % 50) == 0) begin
        tests++;
        if (model_diffs() !== 0) begin failed++; $display("FAIL model_wrap k=%0d %s", k, dmsg); end
      end
    end
    tests++;
    if (!(w0 && w1)) begin failed++; $display("FAIL wrap_seen got %0b/%0b want 1/1", w0, w1); end
    tests++;
    if (lvb !== 3'd0) begin failed++; $display("FAIL wrap_level_b got %0d want 0", lvb); end
    tests++;
    if (model_diffs() !== 0) begin failed++; $display("FAIL model_wrap_end %s", dmsg); end
  endtask

  task automatic test_over_reload();
    logic [9:0] snap [NR][NC];
    logic [2:0] lv0;
    int n;
    bit diff = 0;
    cycle(1'b0, OVER);
    snap = xa;
    lv0 = lva;
    repeat (5) begin cycle(1'b1, OVER); cycle(1'b0, OVER); end
    n = 0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) if (xa[r][c] !== snap[r][c]) n++;
    tests++;
    if (n !== 0 || lva !== lv0) begin failed++; $display("FAIL over_frozen %0d moved, level got %0d want %0d", n, lva, lv0); end

    cycle(1'b1, START);
    n = 0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) if (xa[r][c] !== snap[r][c]) n++;
    tests++;
    if (n !== 0) begin failed++; $display("FAIL reload_tick_moved %0d entries", n); end
    tests++;
    if (lda !== 1'b1 || lva !== 3'd0) begin failed++; $display("FAIL reload_enter loading %b level %0d want 1/0", lda, lva); end

    n = 0;
    do begin cycle(1'b1, PLAYING); n++; end while (lda === 1'b1 && n < 20);
    tests++;
    if (n !== 6) begin failed++; $display("FAIL reload_len got %0d cycles want 6", n); end
    tests++;
    if (lva !== 3'd0) begin failed++; $display("FAIL reload_level got %0d want 0", lva); end
    for (int r = 0; r < NR; r++) if (xa[r][0] !== snap[r][0]) diff = 1;
    tests++;
    if (!diff) begin failed++; $display("FAIL new_phases got same phases want different"); end
    n = 0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (((int'(xa[r][c]) - int'(xa[r][0])) & 1023) != c * SP) n++;
    tests++;
    if (n !== 0) begin failed++; $display("FAIL reload_spacing %0d entries wrong", n); end
    tests++;
    if (model_diffs() !== 0) begin failed++; $display("FAIL model_reload %s", dmsg); end
  endtask

  task automatic test_reset_mid_load();
    int n;
    cycle(1'b0, OVER);
    cycle(1'b0, START);
    repeat (3) cycle(1'b0, START);
    tests++;
    if (lda !== 1'b1) begin failed++; $display("FAIL midload_setup loading got %b want 1", lda); end
    reset = 1'b1;
    cycle(1'b0, START);
    n = 0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) if (xa[r][c] !== 10'(c * SP)) n++;
    tests++;
    if (n !== 0 || lda !== 1'b1 || lva !== 3'd0) begin failed++; $display("FAIL midload_reset %0d x wrong, loading %b level %0d", n, lda, lva); end
    reset = 1'b0;
    n = 0;
    do begin cycle(1'b0, START); n++; end while (lda === 1'b1 && n < 20);
    tests++;
    if (n !== 6) begin failed++; $display("FAIL midload_len got %0d cycles want 6", n); end
    n = 0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        if (xa[r][c] !== 10'((first_ph[r] + c * SP) % 1024)) n++;
    tests++;
    if (n !== 0) begin failed++; $display("FAIL midload_seed %0d entries, x[0][0] got %0d want %0d", n, xa[0][0], first_ph[0]); end
    tests++;
    if (model_diffs() !== 0) begin failed++; $display("FAIL model_midload %s", dmsg); end
  endtask

  initial begin
    test_reset();
    test_start_ticks();
    test_single_tick();
    test_levels();
    test_wrap();
    test_over_reload();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
